qracc_weight_sram: RTL and testbench

Banked weight-SRAM responder on the far side of the controller's `to_sram`/`from_sram` request channel. It accepts one request per cycle when ready. Writes commit in the accept cycle; reads return data one cycle later. After reset and after every clear, it zero-fills every row of every bank before it accepts any traffic. It sits between `qracc_controller` and the analog array's weight storage and owns the bank decode.

---
 rtl/qracc_pkg.sv | 33 +++
 rtl/qracc_wsram_bank.sv | 38 +++
 rtl/qracc_weight_sram.sv | 192 +++++++++++++++++++
 tb/tb_qracc_weight_sram.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types for the qracc weight-SRAM path: request/response channel structs,
// the scrub/ready state encoding and the word-parity helper.
package qracc_pkg;

    localparam int QRACC_NUM_ROWS  = 256;
    localparam int QRACC_NUM_BANKS = 8;
    localparam int QRACC_DATA_W    = 32;
    localparam int QRACC_ADDR_W    = $clog2(QRACC_NUM_ROWS);

    typedef enum logic [0:0] {
        S_SCRUB = 1'b0,
        S_READY = 1'b1
    } wsram_state_t;

    typedef struct packed {
        logic                    rq_valid_i;
        logic                    rq_wr_i;
        logic [QRACC_ADDR_W-1:0] addr_i;
        logic [QRACC_DATA_W-1:0] wr_data_i;
    } to_sram_t;

    typedef struct packed {
        logic                    rq_ready_o;
        logic [QRACC_DATA_W-1:0] rd_data_o;
        logic                    rd_data_valid_o;
    } from_sram_t;

    // Even parity over one data word.
    function automatic logic word_parity(input logic [QRACC_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/qracc_wsram_bank.sv
// One weight bank: single-port array with synchronous write and a registered read port
// whose output holds until the next read.
module qracc_wsram_bank #(
    parameter int numRows   = 256,
    parameter int wordWidth = 33,
    parameter int addrBits  = $clog2(numRows)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [addrBits-1:0]  i_addr,
    input  logic [wordWidth-1:0] i_wdata,
    output logic [wordWidth-1:0] o_rdata
);

    logic [wordWidth-1:0] r_mem [numRows];
    logic [wordWidth-1:0] r_rdata;

    // Array write port; contents are deliberately not reset (the scrub initialises them).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read data, updated only on a read so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/qracc_weight_sram.sv
// Banked weight-SRAM responder: scrub FSM, bank-mask decode and lowest-set-bank read mux.
// Optional per-word parity storage and checking is enabled by QRACC_WSRAM_PARITY_EN.
module qracc_weight_sram
    import qracc_pkg::*;
#(
    parameter int numRows      = QRACC_NUM_ROWS,
    parameter int numBanks     = QRACC_NUM_BANKS,
    parameter int dataBusWidth = QRACC_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  to_sram_t            to_sram,
    input  logic [numBanks-1:0] bank_select,
    input  logic                csr_main_clear,
    output from_sram_t          from_sram,
    output logic                scrub_busy_o,
    output logic                parity_err_o,
    output logic                parity_err_sticky_o,
    input  logic                parity_flip_i
);

    localparam int addrBits   = $clog2(numRows);
    localparam int BANK_IDX_W = (numBanks > 1) ? $clog2(numBanks) : 1;
`ifdef QRACC_WSRAM_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WORD_W = dataBusWidth + PAR_BITS;

    wsram_state_t          r_state;
    wsram_state_t          w_state_nxt;
    logic [addrBits-1:0]   r_scrub_row;
    logic [addrBits-1:0]   w_scrub_row_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [BANK_IDX_W-1:0] w_rd_bank;
    logic [BANK_IDX_W-1:0] r_rd_bank;
    logic                  r_rd_valid;
    logic                  r_rd_zero;
    logic [numBanks-1:0]   w_bank_we;
    logic [numBanks-1:0]   w_bank_re;
    logic [addrBits-1:0]   w_bank_addr;
    logic [WORD_W-1:0]     w_bank_wdata;
    logic [WORD_W-1:0]     w_wr_word;
    logic [WORD_W-1:0]     w_bank_rdata [numBanks];
    logic [WORD_W-1:0]     w_rd_word;

    // Index of the lowest set bit of a bank mask (0 when the mask is empty).
    function automatic logic [BANK_IDX_W-1:0] lowest_bank(input logic [numBanks-1:0] m);
        lowest_bank = '0;
        for (int i = numBanks - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_bank = BANK_IDX_W'(i);
            end else begin
                lowest_bank = lowest_bank;
            end
        end
    endfunction

    assign w_ready   = (r_state == S_READY) && !csr_main_clear;
    assign w_accept  = to_sram.rq_valid_i && w_ready;
    assign w_wr_acc  = w_accept && to_sram.rq_wr_i;
    assign w_rd_acc  = w_accept && !to_sram.rq_wr_i;
    assign w_rd_bank = lowest_bank(bank_select);

    // Next-state logic: a clear always restarts the scrub from row 0.
    always_comb begin
        w_state_nxt     = r_state;
        w_scrub_row_nxt = r_scrub_row;
        case (r_state)
            S_SCRUB: begin
                if (csr_main_clear) begin
                    w_scrub_row_nxt = '0;
                end else if (r_scrub_row == addrBits'(numRows - 1)) begin
                    w_state_nxt     = S_READY;
                    w_scrub_row_nxt = '0;
                end else begin
                    w_scrub_row_nxt = r_scrub_row + addrBits'(1);
                end
            end
            S_READY: begin
                if (csr_main_clear) begin
                    w_state_nxt     = S_SCRUB;
                    w_scrub_row_nxt = '0;
                end else begin
                    w_state_nxt = S_READY;
                end
            end
            default: begin
                w_state_nxt     = S_SCRUB;
                w_scrub_row_nxt = '0;
            end
        endcase
    end

    // State, scrub counter and read-response tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SCRUB;
            r_scrub_row <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_zero   <= 1'b1;
            r_rd_bank   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_scrub_row <= w_scrub_row_nxt;
            r_rd_valid  <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_zero <= ~|bank_select;
                r_rd_bank <= w_rd_bank;
            end
        end
    end

`ifdef QRACC_WSRAM_PARITY_EN
    assign w_wr_word = {word_parity(to_sram.wr_data_i) ^ parity_flip_i, to_sram.wr_data_i};
`else
    assign w_wr_word = to_sram.wr_data_i;
`endif

    // Bank port decode: scrub writes zero (parity 0 is correct for zero) to every bank.
    always_comb begin
        w_bank_we    = '0;
        w_bank_re    = '0;
        w_bank_addr  = to_sram.addr_i;
        w_bank_wdata = w_wr_word;
        if (r_state == S_SCRUB) begin
            w_bank_we    = '1;
            w_bank_addr  = r_scrub_row;
            w_bank_wdata = '0;
        end else if (w_wr_acc) begin
            w_bank_we = bank_select;
        end else if (w_rd_acc && (|bank_select)) begin
            w_bank_re[w_rd_bank] = 1'b1;
        end else begin
            w_bank_re = '0;
        end
    end

    for (genvar g = 0; g < numBanks; g++) begin : g_bank
        qracc_wsram_bank #(
            .numRows   (numRows),
            .wordWidth (WORD_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_bank_we[g]),
            .i_re    (w_bank_re[g]),
            .i_addr  (w_bank_addr),
            .i_wdata (w_bank_wdata),
            .o_rdata (w_bank_rdata[g])
        );
    end

    assign w_rd_word = r_rd_zero ? '0 : w_bank_rdata[r_rd_bank];

    assign from_sram.rq_ready_o      = w_ready;
    assign from_sram.rd_data_o       = w_rd_word[dataBusWidth-1:0];
    assign from_sram.rd_data_valid_o = r_rd_valid;
    assign scrub_busy_o              = (r_state == S_SCRUB);

`ifdef QRACC_WSRAM_PARITY_EN
    logic w_parity_err;
    logic r_err_sticky;

    assign w_parity_err = r_rd_valid && !r_rd_zero &&
                          (w_rd_word[dataBusWidth] != word_parity(w_rd_word[dataBusWidth-1:0]));

    // Sticky error flag; a clear wins over a coincident error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (csr_main_clear) begin
            r_err_sticky <= 1'b0;
        end else if (w_parity_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign parity_err_o        = w_parity_err;
    assign parity_err_sticky_o = r_err_sticky | w_parity_err;
`else
    logic w_unused;
    assign w_unused            = parity_flip_i;
    assign parity_err_o        = 1'b0;
    assign parity_err_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_qracc_weight_sram.sv
// Scoreboard bench for qracc_weight_sram: directed scenarios plus random traffic against
// an array-based reference model. Honours QRACC_WSRAM_PARITY_EN when defined.
module tb_qracc_weight_sram;
    import qracc_pkg::*;

    localparam int NR = 256;
    localparam int NB = 8;
    localparam int DW = 32;
`ifdef QRACC_WSRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    to_sram_t      to_sram;
    logic [NB-1:0] bank_select;
    logic          csr_main_clear;
    from_sram_t    from_sram;
    logic          scrub_busy_o;
    logic          parity_err_o;
    logic          parity_err_sticky_o;
    logic          parity_flip_i;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          sb_q [$];
    logic [DW-1:0] mem [NB][NR];
    bit            bad [NB][NR];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;

    qracc_weight_sram dut (
        .clk                 (clk),
        .rst                 (rst),
        .to_sram             (to_sram),
        .bank_select         (bank_select),
        .csr_main_clear      (csr_main_clear),
        .from_sram           (from_sram),
        .scrub_busy_o        (scrub_busy_o),
        .parity_err_o        (parity_err_o),
        .parity_err_sticky_o (parity_err_sticky_o),
        .parity_flip_i       (parity_flip_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_scrub();
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < NR; r++) begin
                mem[b][r] = '0;
                bad[b][r] = 1'b0;
            end
        end
    endtask

    task automatic drive_idle();
        to_sram.rq_valid_i = 1'b0;
        to_sram.rq_wr_i    = 1'b0;
        to_sram.addr_i     = '0;
        to_sram.wr_data_i  = '0;
        bank_select        = '0;
        csr_main_clear     = 1'b0;
        parity_flip_i      = 1'b0;
    endtask

    // One request cycle; the model decides acceptance (READY unless clear) and expectations.
    task automatic issue(input logic v, input logic wr, input logic [7:0] a, input logic [DW-1:0] d,
                         input logic [NB-1:0] m, input logic clr, input logic flip);
        exp_t e;
        bit   found;
        @(negedge clk);
        to_sram.rq_valid_i = v;
        to_sram.rq_wr_i    = wr;
        to_sram.addr_i     = a;
        to_sram.wr_data_i  = d;
        bank_select        = m;
        csr_main_clear     = clr;
        parity_flip_i      = flip;
        #1;
        check("rq_ready", 64'(from_sram.rq_ready_o), 64'(!clr));
        check("scrub_busy_ready", 64'(scrub_busy_o), 64'd0);
        if (v && !clr) begin
            if (wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (m[b]) begin
                        mem[b][a] = d;
                        bad[b][a] = PAR_EN && flip;
                    end
                end
            end else begin
                e.data = '0;
                e.err  = 1'b0;
                e.cyc  = cyc + 1;
                found  = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    if (m[b] && !found) begin
                        found  = 1'b1;
                        e.data = mem[b][a];
                        e.err  = bad[b][a];
                    end
                end
                sb_q.push_back(e);
            end
        end
        if (clr) model_scrub();
    endtask

    // Idle through the NR scrub cycles that follow a clear, checking ready stays low.
    task automatic wait_scrub();
        logic bad_s = 1'b0;
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            drive_idle();
            #1;
            if (from_sram.rq_ready_o !== 1'b0 || scrub_busy_o !== 1'b1) bad_s = 1'b1;
        end
        check("scrub_window", 64'(bad_s), 64'd0);
    endtask

    // Monitor: every response pops the scoreboard and is compared in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && from_sram.rd_data_valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: valid with empty scoreboard, data 0x%0h", from_sram.rd_data_o);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_data", 64'(from_sram.rd_data_o), 64'(e.data));
                    check("parity_err", 64'(parity_err_o), 64'(e.err));
                    check("rd_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic bad_r;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(from_sram.rq_ready_o), 64'd0);
        check("rst_rd_data", 64'(from_sram.rd_data_o), 64'd0);
        check("rst_rd_valid", 64'(from_sram.rd_data_valid_o), 64'd0);
        check("rst_busy", 64'(scrub_busy_o), 64'd1);
        check("rst_perr", 64'(parity_err_o), 64'd0);
        check("rst_sticky", 64'(parity_err_sticky_o), 64'd0);

        rst   = 1'b0;
        bad_r = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (from_sram.rq_ready_o !== 1'b0 || scrub_busy_o !== 1'b1) bad_r = 1'b1;
            @(negedge clk);
        end
        check("ready_low_256", 64'(bad_r), 64'd0);
        check("ready_rise_257", 64'(from_sram.rq_ready_o), 64'd1);
        model_scrub();

        // Fresh array reads zero; write/read-next-cycle in one bank.
        issue(1'b1, 1'b0, 8'd0, 32'h0, 8'b0000_1000, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 8'b0000_0100, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd5, 32'h0, 8'b0000_0100, 1'b0, 1'b0);

        // Multi-bank write, per-bank reads, lowest-bank mux and zero-mask read.
        issue(1'b1, 1'b1, 8'd9, 32'h12345678, 8'b1010_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd9, 32'h0, 8'b0010_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd9, 32'h0, 8'b1000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 8'd9, 32'hCAFEF00D, 8'b1000_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd9, 32'h0, 8'b1010_0000, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd9, 32'h0, 8'b0000_0000, 1'b0, 1'b0);

        // Back-to-back writes then reads.
        for (int i = 0; i < 4; i++)
            issue(1'b1, 1'b1, 8'(20 + i), 32'hA000_0000 + 32'(i), 8'(1 << i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(1'b1, 1'b0, 8'(20 + i), 32'h0, 8'(1 << i), 1'b0, 1'b0);

        // Clear with a colliding write, with a read still in flight.
        issue(1'b1, 1'b1, 8'd2, 32'h55AA55AA, 8'b0000_0001, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd2, 32'h0, 8'b0000_0001, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 8'd2, 32'hAAAA5555, 8'b0000_0001, 1'b1, 1'b0);
        wait_scrub();
        issue(1'b1, 1'b0, 8'd2, 32'h0, 8'b0000_0001, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 8'd5, 32'h0, 8'b0000_0100, 1'b0, 1'b0);

        // Parity corruption, sticky flag and its clear.
        issue(1'b1, 1'b1, 8'd7, 32'h1, 8'b0000_0001, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 8'd7, 32'h0, 8'b0000_0001, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 8'd0, 32'h0, 8'b0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 8'd0, 32'h0, 8'b0, 1'b0, 1'b0);
        check("sticky_set", 64'(parity_err_sticky_o), 64'(PAR_EN));
        issue(1'b0, 1'b0, 8'd0, 32'h0, 8'b0, 1'b1, 1'b0);
        wait_scrub();
        check("sticky_cleared", 64'(parity_err_sticky_o), 64'd0);

        // Random traffic over a small row window to get frequent hits.
        for (int i = 0; i < 400; i++) begin
            issue(($urandom % 8) != 0, $urandom % 2 == 1, 8'($urandom % 16), $urandom,
                  (($urandom % 4) == 0) ? 8'b0 : 8'($urandom), 1'b0, ($urandom % 16) == 0);
        end

        repeat (3) issue(1'b0, 1'b0, 8'd0, 32'h0, 8'b0, 1'b0, 1'b0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
